// File: rtl/f_result_accumulator_if.sv
// Stream bundle between the F datapath, the block accumulator and its consumer.
// Carries the sample input stream and the per-block result stream.
interface f_result_accumulator_if #(
  parameter int ACC_W = 24
) ();
  // sample stream from the combinational F datapath
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_f;
  logic             flush;

  // per-block result stream towards the consumer
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [15:0]      out_max;
  logic [7:0]       out_count;
  logic             out_ovf;

  // accumulator side: takes samples, produces block results
  modport slave (
    input  in_valid, in_f, flush, out_ready,
    output in_ready, out_valid, out_sum, out_max, out_count, out_ovf
  );

  // environment side: produces samples, consumes block results
  modport master (
    output in_valid, in_f, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_max, out_count, out_ovf
  );
endinterface

// File: rtl/f_result_accumulator.sv
// Block accumulator for the F = ((A >> i) + (B << j)) * C result stream.
// Collects COUNT samples (or fewer on flush) and reports sum, max, count and a
// sticky carry-out flag over a valid/ready result handshake.
module f_result_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  f_result_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] COUNT_LAST = 8'(COUNT);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] sum_reg, sum_next;
  logic [15:0]      max_reg, max_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;

  logic             in_ready_int;
  logic             out_valid_int;
  logic             accept;
  logic             handshake;
  logic             block_full;
  logic             flush_close;
  logic [7:0]       cnt_inc;
  logic [ACC_W:0]   sum_wide;
  logic [ACC_W-1:0] sum_masked;

  // Handshake qualifiers shared by the next-state and datapath logic.
  assign accept      = bus.in_valid && in_ready_int;
  assign handshake   = out_valid_int && bus.out_ready;
  assign cnt_inc     = cnt_reg + 8'd1;
  assign sum_wide    = {1'b0, sum_reg} + {{(ACC_W-15){1'b0}}, bus.in_f};
  assign block_full  = accept && (cnt_inc == COUNT_LAST);
  // An empty block never closes on flush; a flush with an accept includes it.
  assign flush_close = bus.flush && ((cnt_reg != 8'd0) || accept);

  // State and accumulator registers; reset discards any partial or pending block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sum_reg   <= '0;
      max_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      max_reg   <= max_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  // Next-state: IDLE lasts one cycle, ACC closes on full or flush, DONE waits for the consumer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: state_next = ACC;
      ACC: begin
        if (block_full || flush_close) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (handshake) begin
          state_next = ACC;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Accumulator update: add/compare/count on accept, clear once the result is taken.
  always_comb begin
    sum_next = sum_reg;
    max_next = max_reg;
    cnt_next = cnt_reg;
    ovf_next = ovf_reg;
    if (state_reg == ACC && accept) begin
      sum_next = sum_wide[ACC_W-1:0];
      ovf_next = ovf_reg | sum_wide[ACC_W];
      cnt_next = cnt_inc;
      if (cnt_reg == 8'd0 || bus.in_f > max_reg) begin
        max_next = bus.in_f;
      end
    end else if (state_reg == DONE && handshake) begin
      sum_next = '0;
      max_next = '0;
      cnt_next = '0;
      ovf_next = 1'b0;
    end
  end

  // Output decode: ready only in ACC, valid only in DONE, both forced low during reset.
  always_comb begin
    in_ready_int  = 1'b0;
    out_valid_int = 1'b0;
    if (!rst) begin
      in_ready_int  = (state_reg == ACC);
      out_valid_int = (state_reg == DONE);
    end
  end

  // Result fields read as zero whenever no result is being offered.
  generate
    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_sum_mask
      assign sum_masked[gi] = sum_reg[gi] & out_valid_int;
    end
  endgenerate

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.out_sum   = sum_masked;
  assign bus.out_max   = out_valid_int ? max_reg : 16'd0;
  assign bus.out_count = out_valid_int ? cnt_reg : 8'd0;
  assign bus.out_ovf   = out_valid_int & ovf_reg;

  // Never offer a result while taking samples.
  a_exclusive: assert property (@(posedge clk) !(in_ready_int && out_valid_int));

  // A stalled result stays in DONE with unchanged fields.
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid_int && !bus.out_ready) |=>
      (state_reg == DONE && $stable(sum_reg) && $stable(max_reg) &&
       $stable(cnt_reg) && $stable(ovf_reg)));

  // The sample counter never runs past the block size.
  a_cnt_range: assert property (@(posedge clk) cnt_reg <= COUNT_LAST);

endmodule

// File: tb/tb_f_result_accumulator.sv
// Bench for f_result_accumulator: directed cases plus a random stream, checked by
// a scoreboard fed from an abstract block model (sample lists, plain arithmetic).
module tb_f_result_accumulator;

  localparam int COUNT = 4;

  typedef struct {
    logic [31:0] sum;
    logic [15:0] mx;
    logic [7:0]  cnt;
    logic        ovf;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // stimulus per instance: [0] ACC_W=24, [1] ACC_W=16
  logic        in_valid_d[2];
  logic [15:0] in_f_d[2];
  logic        flush_d[2];
  logic        out_ready_d[2];

  // observed outputs per instance
  logic        in_ready_o[2];
  logic        out_valid_o[2];
  logic [31:0] sum_o[2];
  logic [15:0] max_o[2];
  logic [7:0]  cnt_o[2];
  logic        ovf_o[2];

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_done = 1'b0;

  always #5 clk = ~clk;

  f_result_accumulator_if #(.ACC_W(24)) ifa ();
  f_result_accumulator_if #(.ACC_W(16)) ifb ();

  f_result_accumulator #(.COUNT(COUNT), .ACC_W(24)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  f_result_accumulator #(.COUNT(COUNT), .ACC_W(16)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  assign ifa.in_valid  = in_valid_d[0];
  assign ifa.in_f      = in_f_d[0];
  assign ifa.flush     = flush_d[0];
  assign ifa.out_ready = out_ready_d[0];
  assign ifb.in_valid  = in_valid_d[1];
  assign ifb.in_f      = in_f_d[1];
  assign ifb.flush     = flush_d[1];
  assign ifb.out_ready = out_ready_d[1];

  assign in_ready_o[0]  = ifa.in_ready;
  assign out_valid_o[0] = ifa.out_valid;
  assign sum_o[0]       = 32'(ifa.out_sum);
  assign max_o[0]       = ifa.out_max;
  assign cnt_o[0]       = ifa.out_count;
  assign ovf_o[0]       = ifa.out_ovf;
  assign in_ready_o[1]  = ifb.in_ready;
  assign out_valid_o[1] = ifb.out_valid;
  assign sum_o[1]       = 32'(ifb.out_sum);
  assign max_o[1]       = ifb.out_max;
  assign cnt_o[1]       = ifb.out_count;
  assign ovf_o[1]       = ifb.out_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample (optionally with flush) and hold it until it is taken.
  task automatic send(input int k, input logic [15:0] v, input logic fl);
    bit taken;
    taken = 1'b0;
    in_valid_d[k] = 1'b1;
    in_f_d[k]     = v;
    flush_d[k]    = fl;
    for (int t = 0; t < 200 && !taken; t++) begin
      @(negedge clk);
      if (in_ready_o[k]) taken = 1'b1;
      cyc();
    end
    if (!taken) chk("send_timeout", 32'(taken), 32'd1);
    in_valid_d[k] = 1'b0;
    flush_d[k]    = 1'b0;
  endtask

  task automatic flush_only(input int k);
    flush_d[k] = 1'b1;
    cyc();
    flush_d[k] = 1'b0;
  endtask

  // Check the result offered in the current cycle against spec constants.
  task automatic expect_block(input int k, input logic [31:0] s, input logic [15:0] m,
                              input logic [7:0] c, input logic o);
    @(negedge clk);
    chk($sformatf("blk%0d_valid", k), 32'(out_valid_o[k]), 32'd1);
    chk($sformatf("blk%0d_in_ready", k), 32'(in_ready_o[k]), 32'd0);
    chk($sformatf("blk%0d_sum", k), sum_o[k], s);
    chk($sformatf("blk%0d_max", k), 32'(max_o[k]), 32'(m));
    chk($sformatf("blk%0d_count", k), 32'(cnt_o[k]), 32'(c));
    chk($sformatf("blk%0d_ovf", k), 32'(ovf_o[k]), 32'(o));
    cyc();
  endtask

  // Scoreboard per instance: the model side closes blocks from accepted samples,
  // the monitor side compares every offered result with the oldest expected block.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sb
      localparam int W = (gi == 0) ? 24 : 16;
      blk_t        expq[$];
      logic [15:0] part[$];
      int          popped = 0;

      always @(negedge clk) begin : sb_step
        blk_t    b;
        longint  total;
        bit      acc;
        if (rst) begin
          expq.delete();
          part.delete();
        end else begin
          if (out_valid_o[gi]) begin
            if (expq.size() == 0) begin
              chk($sformatf("sb%0d_unexpected_result", gi), 32'd1, 32'd0);
            end else begin
              chk($sformatf("sb%0d_sum", gi), sum_o[gi], expq[0].sum);
              chk($sformatf("sb%0d_max", gi), 32'(max_o[gi]), 32'(expq[0].mx));
              chk($sformatf("sb%0d_count", gi), 32'(cnt_o[gi]), 32'(expq[0].cnt));
              chk($sformatf("sb%0d_ovf", gi), 32'(ovf_o[gi]), 32'(expq[0].ovf));
              if (out_ready_d[gi]) begin
                popped += int'(expq[0].cnt);
                void'(expq.pop_front());
              end
            end
          end else begin
            chk($sformatf("sb%0d_idle_zero", gi),
                sum_o[gi] | 32'(max_o[gi]) | 32'(cnt_o[gi]) | 32'(ovf_o[gi]), 32'd0);
          end

          acc = in_valid_d[gi] && in_ready_o[gi];
          if (acc) part.push_back(in_f_d[gi]);
          if ((acc && part.size() == COUNT) || (flush_d[gi] && part.size() > 0)) begin
            total = 0;
            b.mx  = 16'd0;
            foreach (part[i]) begin
              total += longint'(part[i]);
              if (part[i] > b.mx) b.mx = part[i];
            end
            b.sum = 32'(total % (64'd1 << W));
            b.ovf = (total >= (64'd1 << W));
            b.cnt = 8'(part.size());
            expq.push_back(b);
            part.delete();
          end
        end
      end
    end
  endgenerate

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int base;
    for (int k = 0; k < 2; k++) begin
      in_valid_d[k]  = 1'b0;
      in_f_d[k]      = 16'd0;
      flush_d[k]     = 1'b0;
      out_ready_d[k] = 1'b1;
    end

    // reset values, then the single IDLE cycle
    rst = 1'b1;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_o[0]), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o[0]), 32'd0);
    chk("rst_outputs", sum_o[0] | 32'(max_o[0]) | 32'(cnt_o[0]) | 32'(ovf_o[0]), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready_o[0]), 32'd0);
    chk("idle_out_valid", 32'(out_valid_o[0]), 32'd0);
    cyc();
    @(negedge clk);
    chk("acc_in_ready", 32'(in_ready_o[0]), 32'd1);
    cyc();

    // basic block of four
    send(0, 16'd100, 1'b0);
    send(0, 16'd200, 1'b0);
    send(0, 16'd300, 1'b0);
    send(0, 16'd400, 1'b0);
    expect_block(0, 32'd1000, 16'd400, 8'd4, 1'b0);
    @(negedge clk);
    chk("after_hs_in_ready", 32'(in_ready_o[0]), 32'd1);
    chk("after_hs_out_valid", 32'(out_valid_o[0]), 32'd0);
    cyc();

    // backpressure: result held, pending sample not taken
    out_ready_d[0] = 1'b0;
    send(0, 16'd100, 1'b0);
    send(0, 16'd200, 1'b0);
    send(0, 16'd300, 1'b0);
    send(0, 16'd400, 1'b0);
    in_valid_d[0] = 1'b1;
    in_f_d[0]     = 16'd77;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready_o[0]), 32'd0);
      chk("bp_out_valid", 32'(out_valid_o[0]), 32'd1);
      chk("bp_sum", sum_o[0], 32'd1000);
      chk("bp_max", 32'(max_o[0]), 32'd400);
      chk("bp_count", 32'(cnt_o[0]), 32'd4);
      cyc();
    end
    out_ready_d[0] = 1'b1;
    @(negedge clk);
    chk("bp_hs_in_ready", 32'(in_ready_o[0]), 32'd0);
    cyc();
    @(negedge clk);
    chk("bp_next_accept", 32'(in_ready_o[0]), 32'd1);
    cyc();
    in_valid_d[0] = 1'b0;
    send(0, 16'd1, 1'b0);
    send(0, 16'd2, 1'b0);
    send(0, 16'd3, 1'b0);
    expect_block(0, 32'd83, 16'd77, 8'd4, 1'b0);

    // flush cases
    send(0, 16'd7, 1'b0);
    send(0, 16'd9, 1'b0);
    flush_only(0);
    expect_block(0, 32'd16, 16'd9, 8'd2, 1'b0);
    flush_only(0);
    @(negedge clk);
    chk("flush_empty_a", 32'(out_valid_o[0]), 32'd0);
    cyc();
    @(negedge clk);
    chk("flush_empty_b", 32'(out_valid_o[0]), 32'd0);
    cyc();
    send(0, 16'd5, 1'b1);
    expect_block(0, 32'd5, 16'd5, 8'd1, 1'b0);

    // reset in the middle of a block
    send(0, 16'd50, 1'b0);
    send(0, 16'd60, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready_o[0]), 32'd0);
    chk("midrst_out_valid", 32'(out_valid_o[0]), 32'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle_in_ready", 32'(in_ready_o[0]), 32'd0);
    cyc();
    send(0, 16'd1, 1'b0);
    send(0, 16'd2, 1'b0);
    send(0, 16'd3, 1'b0);
    send(0, 16'd4, 1'b0);
    expect_block(0, 32'd10, 16'd4, 8'd4, 1'b0);

    // overflow on the 16-bit accumulator, sticky flag cleared per block
    for (int n = 0; n < 4; n++) send(1, 16'hFFFF, 1'b0);
    expect_block(1, 32'h0000FFFC, 16'hFFFF, 8'd4, 1'b1);
    for (int n = 0; n < 4; n++) send(1, 16'd1, 1'b0);
    expect_block(1, 32'd4, 16'd1, 8'd4, 1'b0);

    // random stream with random gaps, flushes and consumer stalls
    base = g_sb[0].popped;
    fork
      begin
        for (int n = 0; n < 1200; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) begin
              flush_d[0] = ($urandom_range(0, 9) == 0);
              cyc();
            end
            flush_d[0] = 1'b0;
          end
          send(0, ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
               ($urandom_range(0, 11) == 0));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready_d[0] = ($urandom_range(0, 3) != 0);
          cyc();
        end
      end
    join
    out_ready_d[0] = 1'b1;
    repeat (3) cyc();
    flush_only(0);
    repeat (6) cyc();
    chk("rand_samples_delivered", 32'(g_sb[0].popped - base), 32'd1200);
    chk("rand_queue_empty", 32'(g_sb[0].expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
